// File: rtl/dh_pkg.sv
// Shared Diffie-Hellman definitions: default widths and the exponentiation FSM encoding.
package dh_pkg;

  localparam int unsigned DH_LEN     = 100;
  localparam int unsigned DH_EXP_LEN = 14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SQR  = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } dh_state_e;

endpackage

// File: rtl/mod_mul_serial.sv
// Bit-serial interleaved modular multiplier: r = a*b mod p, MSB of b first, LEN cycles per go.
// The first bit is consumed on the go edge so back-to-back products chain without a gap cycle.
module mod_mul_serial
  import dh_pkg::*;
#(
  parameter int unsigned LEN = DH_LEN
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic [LEN-1:0] a,
  input  logic [LEN-1:0] b,
  input  logic [LEN-1:0] p,
  output logic           busy,
  output logic           done,
  output logic [LEN-1:0] r
);

  localparam int unsigned CW = (LEN > 2) ? $clog2(LEN) : 1;

  logic [LEN-1:0] a_q;
  logic [LEN-1:0] p_q;
  logic [LEN-1:0] b_sh;
  logic [CW-1:0]  cnt;

  // One interleaved step: r' = (2r + bit*a) mod p, with r < p kept at every stage.
  function automatic logic [LEN-1:0] mm_step(input logic [LEN-1:0] r_in,
                                             input logic [LEN-1:0] a_in,
                                             input logic [LEN-1:0] p_in,
                                             input logic           bit_in);
    logic [LEN:0] r2;
    logic [LEN:0] r3;
    r2 = {r_in, 1'b0};
    if (r2 >= {1'b0, p_in}) r2 = r2 - {1'b0, p_in};
    r3 = r2 + (bit_in ? {1'b0, a_in} : {(LEN+1){1'b0}});
    if (r3 >= {1'b0, p_in}) r3 = r3 - {1'b0, p_in};
    return LEN'(r3);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q  <= '0;
      p_q  <= '0;
      b_sh <= '0;
      cnt  <= '0;
      r    <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go) begin
        a_q  <= a;
        p_q  <= p;
        b_sh <= {b[LEN-2:0], 1'b0};
        cnt  <= CW'(LEN - 2);
        r    <= mm_step('0, a, p, b[LEN-1]);
        busy <= 1'b1;
      end else if (busy) begin
        r    <= mm_step(r, a_q, p_q, b_sh[LEN-1]);
        b_sh <= {b_sh[LEN-2:0], 1'b0};
        if (cnt == '0) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/dh_shared_key.sv
// Diffie-Hellman receiver: shared_key = peer_key^secret mod prime by constant-time
// left-to-right square-and-multiply over the serial modular multiplier.
module dh_shared_key
  import dh_pkg::*;
#(
  parameter int unsigned LEN     = DH_LEN,
  parameter int unsigned EXP_LEN = DH_EXP_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               ready,
  input  logic [LEN-1:0]     prime_in,
  input  logic [LEN-1:0]     peer_key_in,
  input  logic [EXP_LEN-1:0] secret_in,
  output logic               done,
  output logic               err,
  output logic [LEN-1:0]     shared_key
);

  localparam int unsigned XW = (EXP_LEN > 1) ? $clog2(EXP_LEN) : 1;

  dh_state_e        state, state_nxt;
  logic [LEN-1:0]     prime_q, peer_q, acc, acc_nxt;
  logic [EXP_LEN-1:0] secret_q;
  logic [XW-1:0]      idx, idx_nxt;
  logic               err_flag, err_flag_nxt;
  logic               done_nxt, err_nxt;
  logic [LEN-1:0]     key_nxt;
  logic               load_c, go_c, mul_go_c;
  logic [LEN-1:0]     mul_a_c, mul_b_c, mul_p_c;
  logic               mul_busy, mul_done;
  logic [LEN-1:0]     mul_r;

  mod_mul_serial #(.LEN(LEN)) u_mul (
    .clk  (clk),
    .rst  (rst),
    .go   (mul_go_c),
    .a    (mul_a_c),
    .b    (mul_b_c),
    .p    (mul_p_c),
    .busy (mul_busy),
    .done (mul_done),
    .r    (mul_r)
  );

  assign mul_go_c = go_c & ~mul_busy;

  // State register plus all datapath/output registers fed from the next-state logic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      prime_q    <= '0;
      peer_q     <= '0;
      secret_q   <= '0;
      acc        <= '0;
      idx        <= '0;
      err_flag   <= 1'b0;
      ready      <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      shared_key <= '0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      idx        <= idx_nxt;
      err_flag   <= err_flag_nxt;
      ready      <= (state_nxt == ST_IDLE);
      done       <= done_nxt;
      err        <= err_nxt;
      shared_key <= key_nxt;
      if (load_c) begin
        prime_q  <= prime_in;
        peer_q   <= peer_key_in;
        secret_q <= secret_in;
      end
    end
  end

  // Each phase hand-off edge also launches the next product, fed from acc_nxt.
  always_comb begin
    state_nxt    = state;
    acc_nxt      = acc;
    idx_nxt      = idx;
    err_flag_nxt = err_flag;
    load_c       = 1'b0;
    go_c         = 1'b0;
    mul_a_c      = acc;
    mul_b_c      = acc;
    mul_p_c      = prime_q;
    done_nxt     = 1'b0;
    err_nxt      = err;
    key_nxt      = shared_key;
    case (state)
      ST_IDLE: begin
        if (start && ready) begin
          load_c  = 1'b1;
          err_nxt = 1'b0;
          idx_nxt = XW'(EXP_LEN - 1);
          acc_nxt = LEN'(1);
          if ((prime_in < LEN'(2)) || (peer_key_in >= prime_in)) begin
            err_flag_nxt = 1'b1;
            state_nxt    = ST_DONE;
          end else begin
            err_flag_nxt = 1'b0;
            state_nxt    = ST_SQR;
            go_c         = 1'b1;
            mul_a_c      = LEN'(1);
            mul_b_c      = LEN'(1);
            mul_p_c      = prime_in;
          end
        end
      end
      ST_SQR: begin
        if (mul_done) begin
          acc_nxt   = mul_r;
          state_nxt = ST_MUL;
          go_c      = 1'b1;
          mul_a_c   = mul_r;
          mul_b_c   = peer_q;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          if (secret_q[idx]) acc_nxt = mul_r;
          if (idx == '0) begin
            state_nxt = ST_DONE;
          end else begin
            idx_nxt   = idx - XW'(1);
            state_nxt = ST_SQR;
            go_c      = 1'b1;
            mul_a_c   = acc_nxt;
            mul_b_c   = acc_nxt;
          end
        end
      end
      ST_DONE: begin
        done_nxt  = 1'b1;
        err_nxt   = err_flag;
        key_nxt   = err_flag ? '0 : acc;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
